fetch_ctrl: RTL and testbench

- Pipeline control for the instruction-fetch stage: drives the PC write-enable and PC source select, supplies the branch target, and controls the IF/ID and ID/EX pipeline registers.
- Sequences post-reset boot hold, load-use stalls, taken-branch redirects with flush, and debug/ecall halt with a deferred redirect.
- Sits between EX/hazard logic and the IF stage; the only block allowed to drive PC_write and PCSrc.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_ctrl_if.sv | 51 +++++
 rtl/fetch_redirect_buf.sv | 32 +++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl shared types: FSM state encoding, NOP constant, XLEN default.
// Imported by the fetch control block and its redirect buffer.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int          XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Hazard/redirect inputs and PC / pipeline-register controls of the IF stage.
// FETCH_PERF_CNT_EN adds the stall_count / flush_count outputs.
interface fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            load_use_hazard;
  logic            branch_taken_EX;
  logic [XLEN-1:0] branch_target_EX;
  logic            halt_req;
  logic            resume;
  logic            PC_write;
  logic            PCSrc;
  logic [XLEN-1:0] PC_Branch;
  logic            IF_ID_write;
  logic            IF_ID_flush;
  logic            ID_EX_flush;
  logic            halted;
  logic            misaligned_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     stall_count;
  logic [31:0]     flush_count;

  modport slave (
    input  load_use_hazard, branch_taken_EX, branch_target_EX,
    input  halt_req, resume,
    output PC_write, PCSrc, PC_Branch, IF_ID_write,
    output IF_ID_flush, ID_EX_flush, halted, misaligned_fault,
    output stall_count, flush_count
  );
  modport master (
    output load_use_hazard, branch_taken_EX, branch_target_EX,
    output halt_req, resume,
    input  PC_write, PCSrc, PC_Branch, IF_ID_write,
    input  IF_ID_flush, ID_EX_flush, halted, misaligned_fault,
    input  stall_count, flush_count
  );
`else
  modport slave (
    input  load_use_hazard, branch_taken_EX, branch_target_EX,
    input  halt_req, resume,
    output PC_write, PCSrc, PC_Branch, IF_ID_write,
    output IF_ID_flush, ID_EX_flush, halted, misaligned_fault
  );
  modport master (
    output load_use_hazard, branch_taken_EX, branch_target_EX,
    output halt_req, resume,
    input  PC_write, PCSrc, PC_Branch, IF_ID_write,
    input  IF_ID_flush, ID_EX_flush, halted, misaligned_fault
  );
`endif
endinterface

// File: rtl/fetch_redirect_buf.sv
// Deferred redirect holder: keeps the branch target seen while halting
// until resume, and flags word-misaligned targets.
module fetch_redirect_buf
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set,
  input  logic            clr,
  input  logic [XLEN-1:0] target_in,
  output logic            aligned,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  assign aligned = is_aligned(target_in[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (set) begin
      pend_valid  <= 1'b1;
      pend_target <= target_in;
    end else if (clr) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage pipeline control: boot hold, load-use stall, branch redirect,
// halt with deferred redirect. Optional FETCH_PERF_CNT_EN perf counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int XLEN        = XLEN_DEF
) (
  input logic        clk,
  input logic        reset,
  fetch_ctrl_if.slave bus
);

  state_t          state_q, state_d;
  logic [3:0]      boot_cnt;
  logic            fault_q, fault_set;
  logic            buf_set, buf_clr, redirect;
  logic            aligned, pend_valid;
  logic [XLEN-1:0] pend_target;

  fetch_redirect_buf #(.XLEN(XLEN)) u_rbuf (
    .clk         (clk),
    .reset       (reset),
    .set         (buf_set),
    .clr         (buf_clr),
    .target_in   (bus.branch_target_EX),
    .aligned     (aligned),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      boot_cnt <= 4'(BOOT_CYCLES);
      fault_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == BOOT && boot_cnt != 4'd0)
        boot_cnt <= boot_cnt - 4'd1;
      if (fault_set)
        fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.PC_write    = 1'b0;
    bus.PCSrc       = 1'b0;
    bus.PC_Branch   = '0;
    bus.IF_ID_write = 1'b0;
    bus.IF_ID_flush = 1'b0;
    bus.ID_EX_flush = 1'b0;
    bus.halted      = 1'b0;
    buf_set         = 1'b0;
    buf_clr         = 1'b0;
    fault_set       = 1'b0;
    redirect        = 1'b0;
    if (reset) begin
      bus.IF_ID_flush = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: begin
          bus.IF_ID_flush = 1'b1;
          if (boot_cnt == 4'd0)
            state_d = RUN;
        end
        RUN: begin
          if (bus.branch_taken_EX) begin
            bus.IF_ID_flush = 1'b1;
            bus.ID_EX_flush = 1'b1;
            if (!aligned) begin
              fault_set = 1'b1;
              state_d   = HALT;
            end else if (bus.halt_req) begin
              buf_set = 1'b1;
              state_d = HALT;
            end else begin
              bus.PCSrc       = 1'b1;
              bus.PC_Branch   = bus.branch_target_EX;
              bus.PC_write    = 1'b1;
              bus.IF_ID_write = 1'b1;
              redirect        = 1'b1;
            end
          end else if (bus.halt_req) begin
            bus.ID_EX_flush = 1'b1;
            state_d         = HALT;
          end else if (bus.load_use_hazard) begin
            bus.ID_EX_flush = 1'b1;
          end else begin
            bus.PC_write    = 1'b1;
            bus.IF_ID_write = 1'b1;
          end
        end
        HALT: begin
          bus.halted      = 1'b1;
          bus.IF_ID_flush = 1'b1;
          if (bus.resume && !bus.halt_req) begin
            state_d = RUN;
            if (pend_valid) begin
              bus.PCSrc     = 1'b1;
              bus.PC_Branch = pend_target;
              bus.PC_write  = 1'b1;
              buf_clr       = 1'b1;
              redirect      = 1'b1;
            end
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  assign bus.misaligned_fault = fault_q & ~reset;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state_q == RUN && !bus.PC_write)
        stall_q <= stall_q + 32'd1;
      if (redirect)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (BOOT_CYCLES = 2).
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  fetch_ctrl_if #(.XLEN(32)) bus ();

  fetch_ctrl #(.BOOT_CYCLES(2), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {PC_write, PCSrc, IF_ID_write, IF_ID_flush, ID_EX_flush, halted}
  logic [5:0] ctrl;
  assign ctrl = {bus.PC_write, bus.PCSrc, bus.IF_ID_write,
                 bus.IF_ID_flush, bus.ID_EX_flush, bus.halted};

  localparam logic [5:0] C_RUN  = 6'b101000;
  localparam logic [5:0] C_BR   = 6'b111110;
  localparam logic [5:0] C_HALT = 6'b000101;
  localparam logic [5:0] C_RST  = 6'b000100;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_use_hazard  = 1'b0;
    bus.branch_taken_EX  = 1'b0;
    bus.branch_target_EX = '0;
    bus.halt_req         = 1'b0;
    bus.resume           = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    adv();
    adv();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RST || bus.misaligned_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctrl=%b fault=%b, want %b 0",
               ctrl, bus.misaligned_fault, C_RST);
    end
    adv();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctrl !== C_RST) begin
        n_fail++;
        $display("FAIL boot_hold[%0d]: got ctrl=%b, want %b", i, ctrl, C_RST);
      end
      adv();
    end
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RUN) begin
      n_fail++;
      $display("FAIL boot_exit: got ctrl=%b, want %b", ctrl, C_RUN);
    end
  endtask

  task automatic test_branch();
    adv();
    bus.branch_taken_EX  = 1'b1;
    bus.branch_target_EX = 32'h40;
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_BR || bus.PC_Branch !== 32'h40) begin
      n_fail++;
      $display("FAIL branch: got ctrl=%b tgt=%h, want %b 00000040",
               ctrl, bus.PC_Branch, C_BR);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RUN || bus.PC_Branch !== 32'h0) begin
      n_fail++;
      $display("FAIL branch_after: got ctrl=%b tgt=%h, want %b 0",
               ctrl, bus.PC_Branch, C_RUN);
    end
  endtask

  task automatic test_load_use();
    adv();
    bus.load_use_hazard = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== 6'b000010) begin
      n_fail++;
      $display("FAIL load_use: got ctrl=%b, want 000010", ctrl);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RUN) begin
      n_fail++;
      $display("FAIL load_use_after: got ctrl=%b, want %b", ctrl, C_RUN);
    end
  endtask

  task automatic test_branch_load_use();
    adv();
    bus.branch_taken_EX  = 1'b1;
    bus.load_use_hazard  = 1'b1;
    bus.branch_target_EX = 32'h80;
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_BR || bus.PC_Branch !== 32'h80) begin
      n_fail++;
      $display("FAIL branch_lu: got ctrl=%b tgt=%h, want %b 00000080",
               ctrl, bus.PC_Branch, C_BR);
    end
    adv();
    idle_inputs();
  endtask

  task automatic test_halt_branch();
    adv();
    bus.halt_req         = 1'b1;
    bus.branch_taken_EX  = 1'b1;
    bus.branch_target_EX = 32'h100;
    @(negedge clk);
    n_checks++;
    if (ctrl !== 6'b000110 || bus.PC_Branch !== 32'h0) begin
      n_fail++;
      $display("FAIL halt_branch: got ctrl=%b tgt=%h, want 000110 0",
               ctrl, bus.PC_Branch);
    end
    adv();
    bus.branch_taken_EX  = 1'b0;
    bus.branch_target_EX = 32'h0;
    bus.resume           = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_HALT) begin
      n_fail++;
      $display("FAIL resume_blocked: got ctrl=%b, want %b", ctrl, C_HALT);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_HALT) begin
      n_fail++;
      $display("FAIL halt_hold: got ctrl=%b, want %b", ctrl, C_HALT);
    end
    adv();
    bus.resume = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== 6'b110101 || bus.PC_Branch !== 32'h100) begin
      n_fail++;
      $display("FAIL resume_pending: got ctrl=%b tgt=%h, want 110101 00000100",
               ctrl, bus.PC_Branch);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RUN) begin
      n_fail++;
      $display("FAIL resume_run: got ctrl=%b, want %b", ctrl, C_RUN);
    end
  endtask

  task automatic test_halt_no_pending();
    adv();
    bus.halt_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== 6'b000010) begin
      n_fail++;
      $display("FAIL halt_req: got ctrl=%b, want 000010", ctrl);
    end
    adv();
    idle_inputs();
    adv();
    bus.resume = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_HALT || bus.PC_Branch !== 32'h0) begin
      n_fail++;
      $display("FAIL resume_nopend: got ctrl=%b tgt=%h, want %b 0",
               ctrl, bus.PC_Branch, C_HALT);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RUN) begin
      n_fail++;
      $display("FAIL nopend_run: got ctrl=%b, want %b", ctrl, C_RUN);
    end
  endtask

  task automatic test_misaligned();
    adv();
    bus.branch_taken_EX  = 1'b1;
    bus.branch_target_EX = 32'h42;
    @(negedge clk);
    n_checks++;
    if (ctrl !== 6'b000110 || bus.PC_Branch !== 32'h0) begin
      n_fail++;
      $display("FAIL misaligned_cycle: got ctrl=%b tgt=%h, want 000110 0",
               ctrl, bus.PC_Branch);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_HALT || bus.misaligned_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_halt: got ctrl=%b fault=%b, want %b 1",
               ctrl, bus.misaligned_fault, C_HALT);
    end
    adv();
    bus.resume = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_HALT || bus.misaligned_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL misaligned_resume: got ctrl=%b fault=%b, want %b 1",
               ctrl, bus.misaligned_fault, C_HALT);
    end
    adv();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RUN || bus.misaligned_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: got ctrl=%b fault=%b, want %b 1",
               ctrl, bus.misaligned_fault, C_RUN);
    end
    adv();
    reset = 1'b1;
    adv();
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RST || bus.misaligned_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: got ctrl=%b fault=%b, want %b 0",
               ctrl, bus.misaligned_fault, C_RST);
    end
    adv();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl !== C_RST || bus.misaligned_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reboot: got ctrl=%b fault=%b, want %b 0",
               ctrl, bus.misaligned_fault, C_RST);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_branch_load_use();
    test_halt_branch();
    test_halt_no_pending();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
